// File: rtl/serial_pkg.sv
// ----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serializer / deserializer pair.
//   SER_WIDTH   : default frame width used by both ends of the serial link.
//   ser_state_e : serializer FSM state encodings (ST_PARITY is only reached
//                 when the serializer is built with PISO_PARITY_EN).
// No ports (package).
// ----------------------------------------------------------------------------
package serial_pkg;

    localparam int SER_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser_state_e;

endpackage : serial_pkg

// File: rtl/piso_serializer.sv
// ----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out stage feeding the serial-to-parallel deserializer.
// A word accepted over valid/ready is shifted out LSB first, one bit per
// clock, starting the cycle after the accept edge. Back-to-back frames run
// with no idle gap when in_valid is held high.
//
// Build option:
//   PISO_PARITY_EN : appends one even-parity bit (XOR of the accepted word)
//                    after the data bits; frames become WIDTH+1 bits and the
//                    completion strobe moves to the parity bit.
//
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   in_data    : parallel word, sampled only on accept
//   in_valid   : in_data is valid
//   in_ready   : block can accept a word this cycle
//   dout       : serial data (deserializer din)
//   dout_valid : dout carries a frame bit this cycle
//   frame_last : dout is the final bit of the current frame
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module piso_serializer
    import serial_pkg::*;
#(
    parameter  int WIDTH = SER_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Even parity of a word: XOR of all bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    ser_state_e       state_q,      state_d;
    logic [WIDTH-1:0] shreg_q,      shreg_d;
    logic [CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic             in_ready_q,   in_ready_d;
    logic             dout_q,       dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             frame_last_q, frame_last_d;
`ifdef PISO_PARITY_EN
    logic             parity_q,     parity_d;
`endif
    logic             accept_s;

    // Next-state logic: accept/reload, shifting and frame termination.
    always_comb begin
        accept_s  = in_valid & in_ready_q;
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
`ifdef PISO_PARITY_EN
                    parity_d  = even_parity(in_data);
`endif
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_q != LAST_CNT) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else begin
`ifdef PISO_PARITY_EN
                    // Data bits done; the parity bit goes out next. The
                    // counter stays parked at LAST_CNT rather than wrapping.
                    state_d = ST_PARITY;
                    shreg_d = '0;
`else
                    // Last data bit on the wire: reload gap-free or go idle.
                    if (accept_s) begin
                        state_d   = ST_SHIFT;
                        shreg_d   = in_data;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = ST_IDLE;
                        shreg_d   = '0;
                        bit_cnt_d = '0;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (accept_s) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    parity_d  = even_parity(in_data);
                end else begin
                    state_d   = ST_IDLE;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end
            end
`endif
            default: begin
                state_d   = ST_IDLE;
                shreg_d   = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        dout_valid_d = (state_d != ST_IDLE);
`ifdef PISO_PARITY_EN
        in_ready_d   = (state_d == ST_IDLE) || (state_d == ST_PARITY);
        frame_last_d = (state_d == ST_PARITY);
        if (state_d == ST_SHIFT) begin
            dout_d = shreg_d[0];
        end else if (state_d == ST_PARITY) begin
            dout_d = parity_d;
        end else begin
            dout_d = 1'b0;
        end
`else
        in_ready_d   = (state_d == ST_IDLE) ||
                       ((state_d == ST_SHIFT) && (bit_cnt_d == LAST_CNT));
        frame_last_d = (state_d == ST_SHIFT) && (bit_cnt_d == LAST_CNT);
        if (state_d == ST_SHIFT) begin
            dout_d = shreg_d[0];
        end else begin
            dout_d = 1'b0;
        end
`endif
    end

    // State and output registers; reset abandons any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            in_ready_q   <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_last_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            in_ready_q   <= in_ready_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_last_q <= frame_last_d;
`ifdef PISO_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_last = frame_last_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// ----------------------------------------------------------------------------
// tb_piso_serializer
// Directed bench for piso_serializer. Expected serial bits are pushed to a
// scoreboard queue when an accept is driven and popped as the DUT emits them.
// A small behavioural deserializer shifts dout in LSB first to rebuild words.
// Handles both the default build and PISO_PARITY_EN.
// ----------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int W = 3;
`ifdef PISO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         dout;
    logic         dout_valid;
    logic         frame_last;
    logic [W-1:0] des_q;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_last (frame_last)
    );

    always #5 clk = ~clk;

    // Reference deserializer: shifts dout in at the MSB, LSB arrives first.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            des_q <= '0;
        end else if (dout_valid) begin
            des_q <= {dout, des_q[W-1:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.b    = d[i];
            e.last = (PAR == 0) && (i == W - 1);
            sb.push_back(e);
        end
`ifdef PISO_PARITY_EN
        e.b    = ^d;
        e.last = 1'b1;
        sb.push_back(e);
`endif
    endtask

    // One clock: record an accept if one will happen, then check the output.
    task automatic step();
        exp_t e;
        if (in_valid && in_ready) push_word(in_data);
        @(posedge clk);
        #1;
        if (dout_valid) begin
            if (sb.size() == 0) begin
                chk("extra_bit", 32'(dout_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("dout", 32'(dout), 32'(e.b));
                chk("frame_last", 32'(frame_last), 32'(e.last));
            end
        end else begin
            chk("idle_dout", 32'(dout), 32'd0);
            chk("idle_last", 32'(frame_last), 32'd0);
            if (sb.size() != 0) chk("missing_bit", 32'(dout_valid), 32'd1);
        end
    endtask

    // Step until every expected bit is out (bounded), plus one edge so the
    // reference deserializer captures the final bit.
    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        step();
    endtask

    initial begin
        // 1: reset state, then idle after release
        #12;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_last", 32'(frame_last), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_ready", 32'(in_ready), 32'd1);
        end

        // 2: single frame 3'b110
        in_data  = 3'b110;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drain();
`ifndef PISO_PARITY_EN
        chk("des_single", 32'(des_q), 32'h6);
`endif
        chk("single_ready", 32'(in_ready), 32'd1);

        // 2b: single frame 3'b100
        in_data  = 3'b100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drain();
`ifndef PISO_PARITY_EN
        chk("des_100", 32'(des_q), 32'h4);
`endif

        // 3: in_valid held high, 101 then 011, gap-free
        in_data  = 3'b101;
        in_valid = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            chk("b2b_ready", 32'(in_ready), 32'((c % FRAME) == 0));
            if (c == 1) in_data = 3'b011;
            step();
`ifndef PISO_PARITY_EN
            if (c == FRAME) chk("des_b2b_a", 32'(des_q), 32'h5);
`endif
        end
        chk("b2b_ready_end", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step();
`ifndef PISO_PARITY_EN
        chk("des_b2b_b", 32'(des_q), 32'h3);
`endif
        drain();

        // 4: asynchronous reset after bit1 of 3'b111
        in_data  = 3'b111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_last", 32'(frame_last), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_des", 32'(des_q), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        in_data  = 3'b010;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drain();
`ifndef PISO_PARITY_EN
        chk("des_post_rst", 32'(des_q), 32'h2);
`endif

        // 5: in_data changes mid-frame are ignored until in_ready
        in_data  = 3'b101;
        in_valid = 1'b1;
        step();
        in_data  = 3'b010;
        for (int c = 1; c < FRAME; c++) begin
            chk("mid_ready", 32'(in_ready), 32'd0);
            step();
        end
        chk("mid_ready_end", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        drain();
`ifndef PISO_PARITY_EN
        chk("des_mid", 32'(des_q), 32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_piso_serializer

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that directly feeds the 3-bit serial-to-parallel deserializer: drives its `din` one bit per clock, LSB first.
- After WIDTH shifts, the downstream register holds the original word in its natural bit order.
- Accepts words over a valid/ready handshake and supports gap-free back-to-back frames.
- Provides a last-bit strobe so the consumer knows when its parallel word is complete.

Parameters:
- WIDTH, 3, data bits per frame; must be >= 2; matches the deserializer width.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- in_data  input  WIDTH  parallel word; sampled only on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial data to deserializer din.
- dout_valid  output  1  dout carries a frame bit this cycle.
- frame_last  output  1  dout is the final bit of the current frame.

Behaviour:
- Reset is asynchronous and active-low. While reset is low:
  - state=IDLE, shreg=0, bit_cnt=0.
  - Outputs: dout=0, dout_valid=0, frame_last=0, in_ready=0.
  - in_ready rises in the first cycle after reset deasserts.
- Accept: an accept happens on a rising edge where in_valid && in_ready. On accept, shreg<=in_data, bit_cnt<=0, state<=SHIFT.
- Latency: bit0 appears on dout in the cycle following the accept edge; one bit per clock after that.
- Output decode:
  - dout = shreg[0] (driven from a register, no combinational path from inputs).
  - dout_valid = (state==SHIFT).
  - frame_last = SHIFT && bit_cnt==WIDTH-1.
- States:
  - IDLE: in_ready=1; dout=0. Goes to SHIFT on accept, otherwise stays.
  - SHIFT, bit_cnt<WIDTH-1: shreg<=shreg>>1 (zero fill), bit_cnt++, in_ready=0.
  - SHIFT, bit_cnt==WIDTH-1: in_ready=1. On accept, reload and restart at bit_cnt=0 with no idle gap. Otherwise go to IDLE with shreg<=0.
- Input rules:
  - in_data and in_valid are ignored whenever in_ready=0; no buffering.
  - A producer may hold in_valid high indefinitely.
  - in_valid must not be gated on in_ready.
- Reset mid-frame: the partial frame is abandoned with no completion strobe. The downstream stage is reset by the same reset.
- Throughput: one word per WIDTH cycles when in_valid is held high.
- The bit counter never wraps past WIDTH-1.

Optional Feature:
- Macro: PISO_PARITY_EN.
- When defined:
  - Adds state PARITY after the last data bit, driving dout = even parity (XOR of the accepted word).
  - Frames become WIDTH+1 bits long.
  - dout_valid=1 during PARITY.
  - frame_last is asserted on the PARITY cycle, not on data bit WIDTH-1.
  - in_ready is high in IDLE and PARITY only; back-to-back reload occurs from PARITY.
  - The parity bit is computed and registered at accept time.
- When undefined:
  - No PARITY state and no parity register.
  - Behaviour exactly as above.

Decomposition:
- Shared package serial_pkg holds:
  - State encodings: ST_IDLE, ST_SHIFT, ST_PARITY.
  - Default frame width constant SER_WIDTH=3, used by both this block and the deserializer.
- No sub-module: the counter, shifter and FSM are small and tightly coupled, so they stay in one module.

Test Plan:
1. Reset release, in_valid=0 for 5 cycles -> dout=0, dout_valid=0, in_ready=1, frame_last never high.
2. Single accept of 3'b110 -> dout 0,1,1 on the next three cycles; frame_last on the third; chained deserializer q=3'b110; then IDLE.
3. in_valid held high with 3'b101 then 3'b011 -> dout 1,0,1,1,1,0 with no gap; in_ready high only on cycles 0, 3 and 6; deserializer q=101 then 011.
4. Assert reset low asynchronously (between edges) after bit1 of 3'b111 -> outputs zero immediately; after release, in_ready=1 and the next word 3'b010 serializes cleanly.
5. Change in_data while in SHIFT -> serialized bits unchanged; new value is ignored until in_ready=1.
6. PISO_PARITY_EN defined:
   - 3'b110 -> dout 0,1,1,0; frame_last on the fourth bit.
   - 3'b100 -> dout 0,0,1,1.
   - Back-to-back period is 4 cycles.
